// File: rtl/core_pkg.sv
// -----------------------------------------------------------------------------
// core_pkg
// Shared definitions for the memory port arbiter:
//   arb_state_t      : arbiter FSM states (IDLE / IF_BUSY / D_BUSY)
//   OWN_IF / OWN_D   : owner encoding of the transaction in flight
//   D_BURST_MAX_DEF  : default number of consecutive data grants while a
//                      fetch is waiting
//   TIMEOUT_CYC_DEF  : default wait-state limit for the optional timeout
//   NOP              : RV32I canonical NOP (addi x0,x0,0), handy as a filler
// -----------------------------------------------------------------------------
package core_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int D_BURST_MAX_DEF = 4;
  localparam int TIMEOUT_CYC_DEF = 255;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/arb_wait_timer.sv
// -----------------------------------------------------------------------------
// arb_wait_timer
// Loadable wait-state counter. Held at zero while i_clear is high, counts up
// while i_en is high, and saturates at LIMIT-1. o_term is high while the
// counter sits at LIMIT-1, i.e. during the LIMIT-th enabled cycle after a
// clear.
// Ports:
//   clk      in  clock
//   nrst     in  synchronous active-low reset
//   i_clear  in  force counter to zero
//   i_en     in  count enable
//   o_term   out terminal flag
// -----------------------------------------------------------------------------
module arb_wait_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic nrst,
  input  logic i_clear,
  input  logic i_en,
  output logic o_term
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] TERM = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!nrst || i_clear) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != TERM)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_term = (r_cnt == TERM);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one external memory port between instruction fetch (if_*) and data
// access (d_*). Transactions are serialised, read data is routed back to the
// owner, and a pipeline stall is derived from the outstanding requests.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   defined   : a wait timer aborts a transaction after TIMEOUT_CYC wait
//               cycles without ex_valid; owner gets rvalid with rdata = 0
//               and err pulses for one cycle.
//   undefined : no timer, err is constant 0, the FSM waits indefinitely.
//
// Ports:
//   clk, nrst                 clock, synchronous active-low reset
//   if_req/if_addr            fetch request (held until if_rvalid)
//   if_gnt/if_rvalid/if_rdata fetch grant pulse, completion pulse, data
//   d_req/d_we/d_addr/d_wdata/d_wstrb
//                             data request (held until d_rvalid)
//   d_gnt/d_rvalid/d_rdata    data grant pulse, completion pulse, data
//                             (d_rdata = 0 on write completion)
//   ex_ren/ex_wen/ex_addr/ex_wdata/ex_wstrb
//                             external port strobes and payload
//   ex_valid/ex_rdata         external completion and read data
//   stall                     pipeline stall request
//   err                       timeout abort pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int D_BURST_MAX = D_BURST_MAX_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  // fetch side
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [DW-1:0]   if_rdata,
  // data side
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wstrb,
  output logic            d_gnt,
  output logic            d_rvalid,
  output logic [DW-1:0]   d_rdata,
  // external port
  output logic            ex_ren,
  output logic            ex_wen,
  output logic [AW-1:0]   ex_addr,
  output logic [DW-1:0]   ex_wdata,
  output logic [DW/8-1:0] ex_wstrb,
  input  logic            ex_valid,
  input  logic [DW-1:0]   ex_rdata,
  // core control
  output logic            stall,
  output logic            err
);

  localparam int BW = DW / 8;
  localparam int CW = (D_BURST_MAX > 0) ? $clog2(D_BURST_MAX + 1) : 1;
  localparam logic [CW-1:0] BURST_LIM = CW'(D_BURST_MAX);

  arb_state_t r_state, w_state_nxt;

  logic          r_if_gnt,    w_if_gnt_nxt;
  logic          r_if_rvalid, w_if_rvalid_nxt;
  logic [DW-1:0] r_if_rdata,  w_if_rdata_nxt;
  logic          r_d_gnt,     w_d_gnt_nxt;
  logic          r_d_rvalid,  w_d_rvalid_nxt;
  logic [DW-1:0] r_d_rdata,   w_d_rdata_nxt;
  logic          r_ex_ren,    w_ex_ren_nxt;
  logic          r_ex_wen,    w_ex_wen_nxt;
  logic [AW-1:0] r_ex_addr,   w_ex_addr_nxt;
  logic [DW-1:0] r_ex_wdata,  w_ex_wdata_nxt;
  logic [BW-1:0] r_ex_wstrb,  w_ex_wstrb_nxt;
  logic          r_err,       w_err_nxt;
  logic [CW-1:0] r_burst_cnt, w_burst_nxt;

  logic          w_if_pend;
  logic          w_d_pend;
  logic          w_idle_open;
  logic          w_force_if;
  logic          w_grant_d;
  logic          w_grant_if;
  logic          w_busy;
  logic          w_abort;
  logic          w_finish;
  logic          w_owner;
  logic [DW-1:0] w_rdata_sel;

  // A requester still sees its own rvalid this cycle, so its held req
  // belongs to the transaction that just completed and must not be re-granted.
  assign w_if_pend = if_req & ~r_if_rvalid;
  assign w_d_pend  = d_req  & ~r_d_rvalid;

  // The completion cycle is the turnaround bubble: no grant is issued while
  // either rvalid is high, so a held data stream and a waiting fetch are
  // arbitrated together in the following cycle.
  assign w_idle_open = (r_state == IDLE) & ~r_if_rvalid & ~r_d_rvalid;

  assign w_force_if = w_if_pend & (r_burst_cnt == BURST_LIM);
  assign w_grant_d  = w_idle_open & w_d_pend & ~w_force_if;
  assign w_grant_if = w_idle_open & w_if_pend & ~w_grant_d;

  assign w_busy  = (r_state == IF_BUSY) | (r_state == D_BUSY);
  assign w_owner = (r_state == D_BUSY) ? OWN_D : OWN_IF;

`ifdef ARB_TIMEOUT_EN
  logic w_tmo_term;

  arb_wait_timer #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (clk),
    .nrst    (nrst),
    .i_clear (~w_busy),
    .i_en    (w_busy),
    .o_term  (w_tmo_term)
  );

  // A completion arriving in the terminal cycle still wins over the abort.
  assign w_abort = w_busy & ~ex_valid & w_tmo_term;
`else
  assign w_abort = 1'b0;
`endif

  assign w_finish    = w_busy & (ex_valid | w_abort);
  assign w_rdata_sel = w_abort ? '0 : ex_rdata;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = D_BUSY;
        end else if (w_grant_if) begin
          w_state_nxt = IF_BUSY;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (w_finish) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM output logic (next values of the registered outputs)
  always_comb begin
    w_if_gnt_nxt    = 1'b0;
    w_d_gnt_nxt     = 1'b0;
    w_if_rvalid_nxt = 1'b0;
    w_d_rvalid_nxt  = 1'b0;
    w_err_nxt       = 1'b0;
    w_if_rdata_nxt  = r_if_rdata;
    w_d_rdata_nxt   = r_d_rdata;
    w_ex_ren_nxt    = r_ex_ren;
    w_ex_wen_nxt    = r_ex_wen;
    w_ex_addr_nxt   = r_ex_addr;
    w_ex_wdata_nxt  = r_ex_wdata;
    w_ex_wstrb_nxt  = r_ex_wstrb;

    unique case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_d_gnt_nxt    = 1'b1;
          w_ex_ren_nxt   = ~d_we;
          w_ex_wen_nxt   = d_we;
          w_ex_addr_nxt  = d_addr;
          w_ex_wdata_nxt = d_wdata;
          w_ex_wstrb_nxt = d_wstrb;
        end else if (w_grant_if) begin
          w_if_gnt_nxt   = 1'b1;
          w_ex_ren_nxt   = 1'b1;
          w_ex_wen_nxt   = 1'b0;
          w_ex_addr_nxt  = if_addr;
          w_ex_wdata_nxt = '0;
          w_ex_wstrb_nxt = '0;
        end
      end
      IF_BUSY, D_BUSY: begin
        if (w_finish) begin
          w_ex_ren_nxt = 1'b0;
          w_ex_wen_nxt = 1'b0;
          w_err_nxt    = w_abort;
          if (w_owner == OWN_D) begin
            w_d_rvalid_nxt = 1'b1;
            w_d_rdata_nxt  = r_ex_wen ? '0 : w_rdata_sel;
          end else begin
            w_if_rvalid_nxt = 1'b1;
            w_if_rdata_nxt  = w_rdata_sel;
          end
        end
      end
      default: begin
        w_ex_ren_nxt = 1'b0;
        w_ex_wen_nxt = 1'b0;
      end
    endcase
  end

  // Burst counter: counts data grants taken while a fetch is waiting.
  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (!if_req || w_grant_if) begin
      w_burst_nxt = '0;
    end else if (w_grant_d && (r_burst_cnt != BURST_LIM)) begin
      w_burst_nxt = r_burst_cnt + CW'(1);
    end
  end

  // Registered outputs and burst counter
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_if_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_gnt     <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      r_ex_ren    <= 1'b0;
      r_ex_wen    <= 1'b0;
      r_ex_addr   <= '0;
      r_ex_wdata  <= '0;
      r_ex_wstrb  <= '0;
      r_err       <= 1'b0;
      r_burst_cnt <= '0;
    end else begin
      r_if_gnt    <= w_if_gnt_nxt;
      r_if_rvalid <= w_if_rvalid_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_gnt     <= w_d_gnt_nxt;
      r_d_rvalid  <= w_d_rvalid_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
      r_ex_ren    <= w_ex_ren_nxt;
      r_ex_wen    <= w_ex_wen_nxt;
      r_ex_addr   <= w_ex_addr_nxt;
      r_ex_wdata  <= w_ex_wdata_nxt;
      r_ex_wstrb  <= w_ex_wstrb_nxt;
      r_err       <= w_err_nxt;
      r_burst_cnt <= w_burst_nxt;
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign d_gnt     = r_d_gnt;
  assign d_rvalid  = r_d_rvalid;
  assign d_rdata   = r_d_rdata;
  assign ex_ren    = r_ex_ren;
  assign ex_wen    = r_ex_wen;
  assign ex_addr   = r_ex_addr;
  assign ex_wdata  = r_ex_wdata;
  assign ex_wstrb  = r_ex_wstrb;
  assign err       = r_err;

  // Stall is gated by nrst so it reads 0 while reset is asserted.
  assign stall = nrst & ((if_req & ~r_if_rvalid) | (d_req & ~r_d_rvalid));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed-vector bench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge. "Cycle k" is the
// clock period following the k-th rising edge of a sequence.
// The timeout sequence is compiled only with ARB_TIMEOUT_EN defined.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import core_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            nrst;
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic            if_gnt;
  logic            if_rvalid;
  logic [DW-1:0]   if_rdata;
  logic            d_req;
  logic            d_we;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic [DW/8-1:0] d_wstrb;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;
  logic            ex_ren;
  logic            ex_wen;
  logic [AW-1:0]   ex_addr;
  logic [DW-1:0]   ex_wdata;
  logic [DW/8-1:0] ex_wstrb;
  logic            ex_valid;
  logic [DW-1:0]   ex_rdata;
  logic            stall;
  logic            err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW          (AW),
    .DW          (DW),
    .D_BURST_MAX (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_wstrb   (d_wstrb),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .ex_ren    (ex_ren),
    .ex_wen    (ex_wen),
    .ex_addr   (ex_addr),
    .ex_wdata  (ex_wdata),
    .ex_wstrb  (ex_wstrb),
    .ex_valid  (ex_valid),
    .ex_rdata  (ex_rdata),
    .stall     (stall),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  logic [9:0] seq;
  int         ng;
  int         coinc;

  initial begin
    nrst     = 1'b0;
    if_req   = 1'b1;
    if_addr  = '0;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    d_wstrb  = '0;
    ex_valid = 1'b0;
    ex_rdata = '0;

    // ---------------- reset state (requests asserted during reset) ----------
    idle(3);
    smp();
    chk("rst_if_gnt", 64'(if_gnt), 64'h0);
    chk("rst_d_gnt",  64'(d_gnt),  64'h0);
    chk("rst_ex_ren", 64'(ex_ren), 64'h0);
    chk("rst_ex_wen", 64'(ex_wen), 64'h0);
    chk("rst_stall",  64'(stall),  64'h0);
    chk("rst_err",    64'(err),    64'h0);
    next_cyc();
    if_req = 1'b0;
    d_req  = 1'b0;
    nrst   = 1'b1;
    idle(2);

    // ---------------- fetch only --------------------------------------------
    next_cyc();                       // cycle 0
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    chk("f_c0_stall", 64'(stall),  64'h1);
    chk("f_c0_gnt",   64'(if_gnt), 64'h0);
    next_cyc(); smp();                // cycle 1
    chk("f_c1_gnt",   64'(if_gnt),  64'h1);
    chk("f_c1_ren",   64'(ex_ren),  64'h1);
    chk("f_c1_addr",  64'(ex_addr), 64'h100);
    chk("f_c1_stall", 64'(stall),   64'h1);
    next_cyc(); smp();                // cycle 2
    chk("f_c2_gnt",   64'(if_gnt),  64'h0);
    chk("f_c2_ren",   64'(ex_ren),  64'h1);
    next_cyc();                       // cycle 3
    ex_valid = 1'b1; ex_rdata = 32'h0050_0093;
    smp();
    chk("f_c3_rvalid", 64'(if_rvalid), 64'h0);
    chk("f_c3_stall",  64'(stall),     64'h1);
    next_cyc();                       // cycle 4
    ex_valid = 1'b0; ex_rdata = '0;
    smp();
    chk("f_c4_rvalid", 64'(if_rvalid), 64'h1);
    chk("f_c4_rdata",  64'(if_rdata),  64'h0050_0093);
    chk("f_c4_ren",    64'(ex_ren),    64'h0);
    chk("f_c4_stall",  64'(stall),     64'h0);
    next_cyc(); smp();
    chk("f_c5_rvalid", 64'(if_rvalid), 64'h0);
    chk("f_c5_regnt",  64'(if_gnt),    64'h0);
    if_req = 1'b0;
    idle(2);

    // ---------------- contention --------------------------------------------
    next_cyc();                       // cycle 0
    if_req = 1'b1; if_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7F0;
    smp();
    chk("c_c0_stall", 64'(stall), 64'h1);
    next_cyc();                       // cycle 1
    ex_valid = 1'b1; ex_rdata = 32'h1111_2222;
    smp();
    chk("c_c1_dgnt",  64'(d_gnt),   64'h1);
    chk("c_c1_ifgnt", 64'(if_gnt),  64'h0);
    chk("c_c1_addr",  64'(ex_addr), 64'h7F0);
    chk("c_c1_ren",   64'(ex_ren),  64'h1);
    next_cyc();                       // cycle 2
    ex_valid = 1'b0;
    smp();
    chk("c_c2_drvalid", 64'(d_rvalid), 64'h1);
    chk("c_c2_drdata",  64'(d_rdata),  64'h1111_2222);
    chk("c_c2_ifgnt",   64'(if_gnt),   64'h0);
    chk("c_c2_ren",     64'(ex_ren),   64'h0);
    next_cyc();                       // cycle 3: bubble
    d_req = 1'b0;
    smp();
    chk("c_c3_ifgnt", 64'(if_gnt), 64'h0);
    next_cyc();                       // cycle 4
    ex_valid = 1'b1; ex_rdata = 32'h3333_4444;
    smp();
    chk("c_c4_ifgnt", 64'(if_gnt),  64'h1);
    chk("c_c4_dgnt",  64'(d_gnt),   64'h0);
    chk("c_c4_addr",  64'(ex_addr), 64'h200);
    next_cyc();                       // cycle 5
    ex_valid = 1'b0;
    smp();
    chk("c_c5_ifrvalid", 64'(if_rvalid), 64'h1);
    chk("c_c5_ifrdata",  64'(if_rdata),  64'h3333_4444);
    next_cyc();
    if_req = 1'b0;
    idle(2);

    // ---------------- fairness (burst limit 4) ------------------------------
    seq = '0; ng = 0; coinc = 0;
    next_cyc();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h7F4;
    if_req = 1'b1; if_addr = 32'h500;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      next_cyc();
      ex_valid = ex_ren | ex_wen;
      ex_rdata = 32'h0BAD_0000 | c;
      smp();
      if (d_gnt && if_gnt) coinc++;
      if (d_gnt) begin
        seq[ng] = 1'b0; ng++;
      end else if (if_gnt) begin
        seq[ng] = 1'b1; ng++;
      end
    end
    chk("fair_ngrants", 64'(ng),    64'd10);
    chk("fair_seq",     64'(seq),   64'h210);
    chk("fair_coinc",   64'(coinc), 64'h0);
    d_req = 1'b0; if_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      next_cyc();
      ex_valid = ex_ren | ex_wen;
    end
    ex_valid = 1'b0;
    smp();
    chk("fair_drain_ren", 64'(ex_ren), 64'h0);
    idle(2);

    // ---------------- data write --------------------------------------------
    next_cyc();                       // cycle 0
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10;
    d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    next_cyc(); smp();                // cycle 1
    chk("w_c1_dgnt",  64'(d_gnt),    64'h1);
    chk("w_c1_wen",   64'(ex_wen),   64'h1);
    chk("w_c1_ren",   64'(ex_ren),   64'h0);
    chk("w_c1_addr",  64'(ex_addr),  64'h10);
    chk("w_c1_wdata", 64'(ex_wdata), 64'hDEAD_BEEF);
    chk("w_c1_wstrb", 64'(ex_wstrb), 64'hF);
    next_cyc(); smp();                // cycle 2
    chk("w_c2_wen",   64'(ex_wen),   64'h1);
    chk("w_c2_wdata", 64'(ex_wdata), 64'hDEAD_BEEF);
    next_cyc();                       // cycle 3
    ex_valid = 1'b1; ex_rdata = 32'h5555_5555;
    smp();
    chk("w_c3_drvalid", 64'(d_rvalid), 64'h0);
    chk("w_c3_ren",     64'(ex_ren),   64'h0);
    next_cyc();                       // cycle 4
    ex_valid = 1'b0;
    smp();
    chk("w_c4_drvalid", 64'(d_rvalid), 64'h1);
    chk("w_c4_drdata",  64'(d_rdata),  64'h0);
    chk("w_c4_wen",     64'(ex_wen),   64'h0);
    chk("w_c4_ren",     64'(ex_ren),   64'h0);
    next_cyc();
    d_req = 1'b0; d_we = 1'b0;
    idle(2);

    // ---------------- reset mid-operation -----------------------------------
    next_cyc();                       // cycle 0
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    next_cyc(); smp();                // cycle 1
    chk("r_c1_dgnt", 64'(d_gnt), 64'h1);
    next_cyc();                       // cycle 2: reset asserted in D_BUSY
    nrst = 1'b0;
    smp();
    chk("r_c2_stall", 64'(stall), 64'h0);
    next_cyc();                       // cycle 3: stray ex_valid
    nrst = 1'b1; d_req = 1'b0;
    ex_valid = 1'b1; ex_rdata = 32'hCAFE_F00D;
    smp();
    chk("r_c3_ren",     64'(ex_ren),   64'h0);
    chk("r_c3_addr",    64'(ex_addr),  64'h0);
    chk("r_c3_drvalid", 64'(d_rvalid), 64'h0);
    next_cyc();                       // cycle 4
    ex_valid = 1'b0;
    smp();
    chk("r_c4_drvalid", 64'(d_rvalid), 64'h0);
    chk("r_c4_drdata",  64'(d_rdata),  64'h0);
    chk("r_c4_stall",   64'(stall),    64'h0);
    next_cyc();                       // fetch after reset
    if_req = 1'b1; if_addr = 32'h300;
    next_cyc();
    ex_valid = 1'b1; ex_rdata = NOP;
    smp();
    chk("r_f_ifgnt", 64'(if_gnt),  64'h1);
    chk("r_f_addr",  64'(ex_addr), 64'h300);
    next_cyc();
    ex_valid = 1'b0;
    smp();
    chk("r_f_rvalid", 64'(if_rvalid), 64'h1);
    chk("r_f_rdata",  64'(if_rdata),  64'(NOP));
    chk("r_f_err",    64'(err),       64'h0);
    next_cyc();
    if_req = 1'b0;
    idle(2);

`ifdef ARB_TIMEOUT_EN
    // ---------------- timeout (TIMEOUT_CYC = 8) -----------------------------
    next_cyc();                       // cycle 0
    if_req = 1'b1; if_addr = 32'h400;
    for (int c = 1; c <= 8; c++) begin
      next_cyc(); smp();
      if (c == 1) chk("t_c1_gnt", 64'(if_gnt), 64'h1);
    end
    chk("t_c8_ren", 64'(ex_ren), 64'h1);
    chk("t_c8_err", 64'(err),    64'h0);
    next_cyc(); smp();                // cycle 9
    chk("t_c9_err",    64'(err),       64'h1);
    chk("t_c9_rvalid", 64'(if_rvalid), 64'h1);
    chk("t_c9_rdata",  64'(if_rdata),  64'h0);
    chk("t_c9_ren",    64'(ex_ren),    64'h0);
    next_cyc();
    if_req = 1'b0;
    smp();
    chk("t_c10_err", 64'(err), 64'h0);
    idle(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
